// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM,
// registered level/press/release/long-press outputs and a wrapping press counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [7:0] press_count
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_MAX        = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX      = HOLD_W'(LONG_CYCLES - 1);
  localparam logic              P_IDLE_PIN    = (KEY_ACTIVE_LOW != 0);
  localparam logic              LONG_AT_ENTRY = (LONG_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_PRESSED,
    S_REL_DB
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [DB_W-1:0]   r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic              r_long_fired;
  logic              r_press_evt;
  logic              r_release_evt;
  logic              r_long_evt;
  logic              r_key_state;
  logic              r_key_press;
  logic              r_key_release;
  logic              r_key_long;
  logic [7:0]        r_press_count;

  logic              w_ks;
  logic [HOLD_W-1:0] w_hold_inc;

  // Sync flops reset to the idle pin level so leaving reset with the key up is silent.
  // NOTE: every flop uses <= so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= P_IDLE_PIN;
      r_sync2 <= P_IDLE_PIN;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ks       = r_sync2 ^ P_IDLE_PIN;
  assign w_hold_inc = r_hold + HOLD_W'(1);

  // Events are raised on the state-transition edge and surface one edge later,
  // together with the matching key_state and press_count update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_long_fired  <= 1'b0;
      r_press_evt   <= 1'b0;
      r_release_evt <= 1'b0;
      r_long_evt    <= 1'b0;
      r_key_state   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
      r_key_long    <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_press_evt   <= 1'b0;
      r_release_evt <= 1'b0;
      r_long_evt    <= 1'b0;
      r_key_press   <= r_press_evt;
      r_key_release <= r_release_evt;
      r_key_long    <= r_long_evt;
      if (r_press_evt) begin
        r_key_state   <= 1'b1;
        r_press_count <= r_press_count + 8'd1;
      end
      if (r_release_evt) begin
        r_key_state <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_ks) begin
            r_state <= S_PRESS_DB;
            r_cnt   <= '0;
          end
        end
        S_PRESS_DB: begin
          if (!w_ks) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_MAX) begin
            r_state     <= S_PRESSED;
            r_cnt       <= '0;
            r_press_evt <= 1'b1;
            if (LONG_AT_ENTRY) begin
              r_long_evt   <= 1'b1;
              r_long_fired <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        S_PRESSED: begin
          if (r_hold != HOLD_MAX) begin
            r_hold <= w_hold_inc;
            if (w_hold_inc == HOLD_MAX && !r_long_fired) begin
              r_long_evt   <= 1'b1;
              r_long_fired <= 1'b1;
            end
          end
          if (!w_ks) begin
            r_state <= S_REL_DB;
            r_cnt   <= '0;
          end
        end
        S_REL_DB: begin
          // Hold counter and long flag survive a release bounce so key_long never re-arms.
          if (w_ks) begin
            r_state <= S_PRESSED;
          end else if (r_cnt == DB_MAX) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_long_fired  <= 1'b0;
            r_release_evt <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_state   = r_key_state;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign key_long    = r_key_long;
  assign press_count = r_press_count;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, active-low pin.
// Edge E is the first rising edge that samples a new key_in value; pulses land at E+7.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       key_state;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output vector layout: {key_state, key_press, key_release, key_long, press_count}.
  task automatic test_reset();
    logic [11:0] got;
    rst    = 1'b1;
    key_in = 1'b1;
    tick();
    tick();
    got = {key_state, key_press, key_release, key_long, press_count};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", got, 12'h000);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      checks++;
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got=%h exp=%h", i, got, 12'h000);
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic [11:0] got;
    for (int i = 0; i < 20; i++) begin
      key_in = (i < 3) ? 1'b0 : (i == 3) ? 1'b1 : (i < 6) ? 1'b0 : 1'b1;
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      checks++;
      if (got !== 12'h000) begin
        errors++;
        $display("FAIL bounce_reject cycle=%0d got=%h exp=%h", i, got, 12'h000);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [11:0] got;
    logic [11:0] exp;
    key_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i >= 7), (i == 7), 1'b0, 1'b0, (i >= 7) ? 8'd1 : 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press E+%0d got=%h exp=%h", i, got, exp);
      end
    end
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i < 7), 1'b0, (i == 7), 1'b0, 8'd1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_release E+%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_long_press();
    logic [11:0] got;
    logic [11:0] exp;
    key_in = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i >= 7), (i == 7), 1'b0, (i == 16), (i >= 7) ? 8'd2 : 8'd1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_press E+%0d got=%h exp=%h", i, got, exp);
      end
    end
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i < 7), 1'b0, (i == 7), 1'b0, 8'd2};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_release E+%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [11:0] got;
    logic [11:0] exp;
    key_in = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i >= 7), (i == 7), 1'b0, (i == 16), (i >= 7) ? 8'd3 : 8'd2};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rb_press E+%0d got=%h exp=%h", i, got, exp);
      end
    end
    for (int i = 0; i < 20; i++) begin
      key_in = (i < 2) ? 1'b1 : 1'b0;
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rb_bounce cycle=%0d got=%h exp=%h", i, got, exp);
      end
    end
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i < 7), 1'b0, (i == 7), 1'b0, 8'd3};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rb_release E+%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [11:0] got;
    logic [11:0] exp;
    rst    = 1'b1;
    key_in = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 256; k++) begin
      key_in = 1'b0;
      repeat (10) tick();
      key_in = 1'b1;
      repeat (10) tick();
      if (k == 0 || k == 254 || k == 255) begin
        exp[7:0] = (k == 0) ? 8'd1 : (k == 254) ? 8'd255 : 8'd0;
        checks++;
        if (press_count !== exp[7:0]) begin
          errors++;
          $display("FAIL wrap_count presses=%0d got=%0d exp=%0d", k + 1, press_count, exp[7:0]);
        end
      end
    end
    key_in = 1'b0;
    repeat (10) tick();
    got = {key_state, key_press, key_release, key_long, press_count};
    checks++;
    if (got !== {4'b1000, 8'd1}) begin
      errors++;
      $display("FAIL held_before_rst got=%h exp=%h", got, {4'b1000, 8'd1});
    end
    rst = 1'b1;
    #1;
    got = {key_state, key_press, key_release, key_long, press_count};
    checks++;
    if (got !== 12'h000) begin
      errors++;
      $display("FAIL async_rst got=%h exp=%h", got, 12'h000);
    end
    tick();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      got = {key_state, key_press, key_release, key_long, press_count};
      exp = {(i >= 7), (i == 7), 1'b0, 1'b0, (i >= 7) ? 8'd1 : 8'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_rst_press E+%0d got=%h exp=%h", i, got, exp);
      end
    end
    key_in = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 1'b1;
    test_reset();
    test_bounce_reject();
    test_clean_press();
    test_long_press();
    test_release_bounce();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
Input-side counterpart to the board's LED output drivers. Reads one raw mechanical push-button and runs it through a two-flop synchronizer and a debounce state machine. Produces a clean level plus single-cycle press, release and long-press pulses, and keeps a wrapping press counter. Sits between a board key pin and user logic such as LED mode selection or blink-rate stepping.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be >= 1.
LONG_CYCLES, 50000000, cycles spent in PRESSED before key_long fires (1 s at 50 MHz); must be >= 1.
KEY_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board default); 0 = pin reads 1 when pressed.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
key_in  input  1  raw, unsynchronized button pin.
key_state  output  1  debounced level; 1 = pressed.
key_press  output  1  one-cycle pulse on each accepted press.
key_release  output  1  one-cycle pulse on each accepted release.
key_long  output  1  one-cycle pulse, at most once per press, after LONG_CYCLES in PRESSED.
press_count  output  8  number of accepted presses; wraps from 255 to 0.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset: state = IDLE, all counters = 0, all outputs = 0. The sync flops load the inactive pin level, so releasing reset with the key idle causes no event.
- Synchronizer: two flops, then polarity normalization (XOR with KEY_ACTIVE_LOW) gives ks, where 1 = pressed.
- Debounce counter width: enough bits for DEBOUNCE_CYCLES-1. Hold counter width: enough bits for LONG_CYCLES-1.
- State machine, four states:
  - IDLE: if ks = 1, go to PRESS_DB with cnt = 0.
  - PRESS_DB: if ks = 0, go back to IDLE (bounce) and set cnt = 0. If ks = 1 and cnt == DEBOUNCE_CYCLES-1, go to PRESSED; otherwise cnt++.
  - PRESSED: hold counter increments, saturating at LONG_CYCLES-1. key_long pulses on the cycle the hold counter first reaches LONG_CYCLES-1, and never again within the same press. If ks = 0, go to REL_DB with cnt = 0.
  - REL_DB: if ks = 1, go back to PRESSED. The hold counter and the long-fired flag are preserved, so a bounce never re-arms key_long. If ks = 0 and cnt == DEBOUNCE_CYCLES-1, go to IDLE and clear the hold counter and long flag; otherwise cnt++.
- Outputs (all registered):
  - key_press: asserted for the one cycle after entry into PRESSED from PRESS_DB.
  - key_release: asserted for the one cycle after entry into IDLE from REL_DB.
  - key_state: 1 in PRESSED and REL_DB, 0 otherwise. It changes on the same edge as the corresponding pulse.
  - press_count: increments on the same edge that key_press rises.
- Latency: a clean edge on key_in to the pulse edge is exactly 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
- Pulse exclusivity: key_press and key_release are never high together. key_long and key_press can coincide only when LONG_CYCLES = 1.
- Glitches: any ks glitch shorter than DEBOUNCE_CYCLES produces no pulse and leaves key_state unchanged.
- Reset mid-press: no key_release is emitted. If the key is still held after rst deasserts, a full debounce runs and a new key_press is produced. press_count restarts from 0.
- Pin held through reset: if key_in is active during and after reset, the first key_press follows the nominal latency measured from rst deassertion.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10, KEY_ACTIVE_LOW=1.
- Reset idle: rst high, key_in=1, then rst low for 20 cycles -> all outputs stay 0, no pulses.
- Clean press: key_in 1->0 at edge E -> key_press high only at E+7, key_state=1 from E+7, press_count=1.
- Bounce rejection: key_in low for 3 cycles, high for 1, low for 2, then high -> no key_press, key_state stays 0, press_count=0.
- Long press: hold key_in=0 for 30 cycles -> key_press at E+7, exactly one key_long pulse 9 cycles after key_press, no second key_long. Then release -> one key_release 7 cycles after the release edge.
- Release bounce: while pressed, key_in high for 2 cycles then low again -> no key_release, key_state stays 1, no extra key_long.
- Wrap and reset: 256 clean presses -> press_count reads 0. Then press, assert rst while held, release rst -> outputs cleared, no key_release, a fresh key_press 7 cycles after rst deassertion, press_count=1.
